mem_responder: RTL and testbench

- Data-memory responder: the target end of the core's load/store memory interface.
- Accepts one request at a time over a valid/ready handshake and inserts LATENCY wait cycles.
- Performs a byte-, halfword- or word-sized read or write on an internal word array, then returns a response over a second valid/ready handshake.
- Address space starts at BASE, the core's reset PC region. Access size and sign are encoded in funct3 exactly as in RV32I loads and stores.

---
 rtl/mem_responder.sv | 184 ++++++++++++++++++
 tb/tb_mem_responder.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : mem_responder
//  Purpose  : Target end of the core's load/store data-memory interface.
//             Accepts one request at a time, waits LATENCY cycles, performs a
//             byte/halfword/word access on an internal word array (funct3
//             encoded as in RV32I), then returns a response.
//  Ports    : clk, rst (sync, active-high)
//             req_valid/req_ready, req_we, req_func[2:0], req_addr[31:0],
//             req_wdata[31:0]                       -- request channel
//             rsp_valid/rsp_ready, rsp_rdata[31:0], rsp_err -- response channel
//  Options  : `define MEM_MISALIGN_ERR_EN to fault misaligned H/HU/W accesses.
//  Revision : 1.0  initial release
// ============================================================================
module mem_responder #(
   parameter logic [31:0] BASE        = 32'h8000_0000,
   parameter int          DEPTH_WORDS = 16384,
   parameter int          LATENCY     = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_func,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int IDX_W = $clog2(DEPTH_WORDS);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t      state, state_nxt;
   logic [3:0]  cnt;
   logic        we_q;
   logic [2:0]  func_q;
   logic [31:0] addr_q, wdata_q;
   logic        accept, exec;

   logic [31:0] mem [DEPTH_WORDS];

   // Access operands: with LATENCY=0 the access executes on the accept edge,
   // before the request has been latched, so take it straight from the port.
   logic        a_we;
   logic [2:0]  a_func;
   logic [31:0] a_addr, a_wdata;

   logic [31:0] off;
   logic        in_range, legal, misalign, fault;
   logic [IDX_W-1:0] idx;
   logic [31:0] word, ld_data, st_mask, st_data, st_word;
   logic [4:0]  bsh;
   logic [7:0]  lane_b;
   logic [15:0] lane_h;

   // ---------------------------------------------------------------- FSM
   always_comb begin
      state_nxt = state;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      accept    = 1'b0;
      exec      = 1'b0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               accept    = 1'b1;
               exec      = (LATENCY == 0);
               state_nxt = (LATENCY == 0) ? RESP : WAIT;
            end
         end
         WAIT: begin
            if (cnt == 4'd0) begin
               exec      = 1'b1;
               state_nxt = RESP;
            end
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= 4'd0;
         rsp_rdata <= 32'd0;
         rsp_err   <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            we_q    <= req_we;
            func_q  <= req_func;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            cnt     <= 4'(LATENCY - 1);
         end else if (state == WAIT && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
         end
         if (exec) begin
            rsp_err   <= fault;
            rsp_rdata <= (fault || a_we) ? 32'd0 : ld_data;
         end
      end
   end

   // ---------------------------------------------------------------- access decode
   always_comb begin
      a_we    = (state == IDLE) ? req_we    : we_q;
      a_func  = (state == IDLE) ? req_func  : func_q;
      a_addr  = (state == IDLE) ? req_addr  : addr_q;
      a_wdata = (state == IDLE) ? req_wdata : wdata_q;

      // BASE is word aligned, so off[1:0] equals the address lane bits.
      off      = a_addr - BASE;
      in_range = (a_addr >= BASE) && ({2'b00, off[31:2]} < 32'(DEPTH_WORDS));
      idx      = off[IDX_W+1:2];

      case (a_func)
         3'b000, 3'b001, 3'b010: legal = 1'b1;
         3'b100, 3'b101:         legal = !a_we;
         default:                legal = 1'b0;
      endcase

`ifdef MEM_MISALIGN_ERR_EN
      misalign = ((a_func[1:0] == 2'b01) && off[0]) ||
                 ((a_func[1:0] == 2'b10) && (off[1:0] != 2'b00));
`else
      misalign = 1'b0;
`endif

      fault  = !in_range || !legal || misalign;

      word   = mem[idx];
      bsh    = {off[1:0], 3'b000};
      lane_b = word[bsh +: 8];
      lane_h = off[1] ? word[31:16] : word[15:0];

      case (a_func)
         3'b000:  ld_data = {{24{lane_b[7]}}, lane_b};
         3'b001:  ld_data = {{16{lane_h[15]}}, lane_h};
         3'b100:  ld_data = {24'd0, lane_b};
         3'b101:  ld_data = {16'd0, lane_h};
         default: ld_data = word;
      endcase

      // Read-modify-write: replicate the store data across lanes and keep
      // only the bytes selected by the mask.
      case (a_func)
         3'b000: begin
            st_mask = 32'h0000_00FF << bsh;
            st_data = {4{a_wdata[7:0]}};
         end
         3'b001: begin
            st_mask = off[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
            st_data = {2{a_wdata[15:0]}};
         end
         default: begin
            st_mask = 32'hFFFF_FFFF;
            st_data = a_wdata;
         end
      endcase
      st_word = (word & ~st_mask) | (st_data & st_mask);
   end

   // Single commit point per store; a reset in the same cycle drops it.
   always_ff @(posedge clk) begin
      if (exec && !rst && a_we && !fault) mem[idx] <= st_word;
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_responder
//  Purpose  : Self-checking bench for mem_responder: directed scenarios plus
//             randomized traffic against a behavioural memory model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_responder;

   localparam logic [31:0] BASE    = 32'h8000_0000;
   localparam int          DEPTH   = 16384;
   localparam int          LATENCY = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_we;
   logic [2:0]  req_func;
   logic [31:0] req_addr, req_wdata;
   logic        rsp_valid, rsp_ready, rsp_err;
   logic [31:0] rsp_rdata;

   int checks = 0;
   int errors = 0;

   logic [31:0] ref_mem [int unsigned];

   always #5 clk = ~clk;

   mem_responder #(.BASE(BASE), .DEPTH_WORDS(DEPTH), .LATENCY(LATENCY)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_func(req_func), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h expected=%h", tag, got, exp);
      end
   endtask

   // Reference model: the memory as a sparse array of words, accesses
   // computed from the address arithmetic directly.
   function automatic void model(input bit we, input logic [2:0] f, input logic [31:0] a,
                                 input logic [31:0] wd, output logic [31:0] rd, output bit err);
      bit          bad;
      int unsigned idx, shb, shh, sh;
      logic [31:0] w, m;
      logic [7:0]  b;
      logic [15:0] h;
      rd  = 32'd0;
      err = 1'b0;
      bad = (a < BASE) || ((longint'(a) - longint'(BASE)) / 4 >= longint'(DEPTH));
      if (we) bad = bad || !(f inside {3'd0, 3'd1, 3'd2});
      else    bad = bad || !(f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
`ifdef MEM_MISALIGN_ERR_EN
      if ((f == 3'd1 || f == 3'd5) && (a % 2 != 0)) bad = 1'b1;
      if (f == 3'd2 && (a % 4 != 0)) bad = 1'b1;
`endif
      if (bad) begin
         err = 1'b1;
         return;
      end
      idx = (a - BASE) / 4;
      w   = ref_mem.exists(idx) ? ref_mem[idx] : 32'd0;
      shb = 8 * (a % 4);
      shh = 16 * ((a % 4) / 2);
      b   = 8'(w >> shb);
      h   = 16'(w >> shh);
      if (!we) begin
         case (f)
            3'd0:    rd = 32'($signed(b));
            3'd1:    rd = 32'($signed(h));
            3'd4:    rd = 32'(b);
            3'd5:    rd = 32'(h);
            default: rd = w;
         endcase
      end else begin
         case (f)
            3'd0:    begin m = 32'hFF   << shb; sh = shb; end
            3'd1:    begin m = 32'hFFFF << shh; sh = shh; end
            default: begin m = 32'hFFFF_FFFF;   sh = 0;   end
         endcase
         ref_mem[idx] = (w & ~m) | ((wd << sh) & m);
      end
   endfunction

   task automatic send(input bit we, input logic [2:0] f, input logic [31:0] a, input logic [31:0] wd);
      int n = 0;
      @(negedge clk);
      while (!req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) check("req_ready_wait", {31'd0, req_ready}, 32'd1);
      req_valid = 1'b1;
      req_we    = we;
      req_func  = f;
      req_addr  = a;
      req_wdata = wd;
      @(posedge clk);
      #1 req_valid = 1'b0;
   endtask

   task automatic wait_rsp(output int lat);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!rsp_valid && lat < 50);
   endtask

   task automatic txn(input bit we, input logic [2:0] f, input logic [31:0] a,
                      input logic [31:0] wd, output logic [31:0] rd, output bit err);
      int          lat;
      logic [31:0] erd;
      bit          eerr;
      send(we, f, a, wd);
      model(we, f, a, wd, erd, eerr);
      wait_rsp(lat);
      check($sformatf("latency@%h", a), lat, LATENCY + 1);
      rd  = rsp_rdata;
      err = rsp_err;
      check($sformatf("rdata@%h f%0d we%0d", a, f, we), rsp_rdata, erd);
      check($sformatf("err@%h f%0d we%0d", a, f, we), {31'd0, rsp_err}, {31'd0, eerr});
      @(posedge clk);
      #1;
      check("rsp_valid_drop", {31'd0, rsp_valid}, 32'd0);
      check("req_ready_rise", {31'd0, req_ready}, 32'd1);
   endtask

   logic [31:0] waddr [9];

   initial begin
      logic [31:0] rd;
      bit          er;
      int          lat;

      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_func = 3'd0;
      req_addr = 32'd0; req_wdata = 32'd0; rsp_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_req_ready", {31'd0, req_ready}, 32'd1);
      check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("rst_rdata", rsp_rdata, 32'd0);
      check("rst_err", {31'd0, rsp_err}, 32'd0);
      rst = 1'b0;

      // Word store / load
      txn(1, 3'd2, 32'h8000_0010, 32'hDEAD_BEEF, rd, er);
      txn(0, 3'd2, 32'h8000_0010, 32'd0, rd, er);
      check("tp_w", rd, 32'hDEAD_BEEF);

      // Byte merge and extension
      txn(1, 3'd2, 32'h8000_0020, 32'h1122_3344, rd, er);
      txn(1, 3'd0, 32'h8000_0022, 32'h0000_00AA, rd, er);
      txn(0, 3'd2, 32'h8000_0020, 32'd0, rd, er);
      check("tp_bmerge", rd, 32'h11AA_3344);
      txn(0, 3'd0, 32'h8000_0022, 32'd0, rd, er);
      check("tp_lb", rd, 32'hFFFF_FFAA);
      txn(0, 3'd4, 32'h8000_0022, 32'd0, rd, er);
      check("tp_lbu", rd, 32'h0000_00AA);

      // Halfword extension
      txn(1, 3'd2, 32'h8000_0030, 32'h8001_7FFF, rd, er);
      txn(0, 3'd1, 32'h8000_0030, 32'd0, rd, er);
      check("tp_lh0", rd, 32'h0000_7FFF);
      txn(0, 3'd1, 32'h8000_0032, 32'd0, rd, er);
      check("tp_lh2", rd, 32'hFFFF_8001);
      txn(0, 3'd5, 32'h8000_0032, 32'd0, rd, er);
      check("tp_lhu", rd, 32'h0000_8001);

      // Range and func faults
      txn(0, 3'd2, 32'h7FFF_FFFC, 32'd0, rd, er);
      check("tp_below_err", {31'd0, er}, 32'd1);
      check("tp_below_rd", rd, 32'd0);
      txn(0, 3'd2, BASE + 32'(4 * DEPTH), 32'd0, rd, er);
      check("tp_above_err", {31'd0, er}, 32'd1);
      check("tp_above_rd", rd, 32'd0);
      txn(1, 3'd3, 32'h8000_0030, 32'h0BAD_0BAD, rd, er);
      check("tp_badfunc_err", {31'd0, er}, 32'd1);
      txn(0, 3'd2, 32'h8000_0030, 32'd0, rd, er);
      check("tp_badfunc_mem", rd, 32'h8001_7FFF);

      // Response stall with an ignored second request
      rsp_ready = 1'b0;
      send(1, 3'd2, 32'h8000_0050, 32'hCAFE_F00D);
      model(1, 3'd2, 32'h8000_0050, 32'hCAFE_F00D, rd, er);
      wait_rsp(lat);
      check("stall_latency", lat, LATENCY + 1);
      req_valid = 1'b1; req_we = 1'b1; req_func = 3'd2;
      req_addr = 32'h8000_0050; req_wdata = 32'h0BAD_BEEF;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("stall_valid", {31'd0, rsp_valid}, 32'd1);
         check("stall_rdata", rsp_rdata, 32'd0);
         check("stall_err", {31'd0, rsp_err}, 32'd0);
         check("stall_req_ready", {31'd0, req_ready}, 32'd0);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 check("stall_release", {31'd0, rsp_valid}, 32'd0);
      txn(0, 3'd2, 32'h8000_0050, 32'd0, rd, er);
      check("stall_mem", rd, 32'hCAFE_F00D);

      // Reset during WAIT aborts the store
      txn(1, 3'd2, 32'h8000_0040, 32'd0, rd, er);
      send(1, 3'd2, 32'h8000_0040, 32'h1234_5678);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("abort_req_ready", {31'd0, req_ready}, 32'd1);
      check("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      rst = 1'b0;
      repeat (LATENCY + 2) @(negedge clk);
      check("abort_no_rsp", {31'd0, rsp_valid}, 32'd0);
      txn(0, 3'd2, 32'h8000_0040, 32'd0, rd, er);
      check("abort_mem", rd, 32'd0);

      // Misaligned word load
      txn(0, 3'd2, 32'h8000_0041, 32'd0, rd, er);
`ifdef MEM_MISALIGN_ERR_EN
      check("misalign_err", {31'd0, er}, 32'd1);
`else
      check("misalign_rd", rd, 32'd0);
`endif

      // Randomized traffic over a small set of initialized words, including
      // the last word of the array, plus occasional out-of-range addresses.
      for (int i = 0; i < 8; i++) waddr[i] = 32'h8000_0100 + 32'(4 * i);
      waddr[8] = BASE + 32'(4 * (DEPTH - 1));
      for (int i = 0; i < 9; i++) txn(1, 3'd2, waddr[i], $urandom, rd, er);
      for (int i = 0; i < 250; i++) begin
         logic [31:0] a;
         case ($urandom_range(0, 9))
            0:       a = 32'h7FFF_FFFC + 32'($urandom_range(0, 3));
            1:       a = BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 3));
            default: a = waddr[$urandom_range(0, 8)] + 32'($urandom_range(0, 3));
         endcase
         txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom, rd, er);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
